// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : 640x480@60 timing defaults, derived totals, sync positions.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_CNT_W    = 10;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int c_H_TOTAL      = line_total(c_H_ACTIVE, c_H_FP, c_H_SYNC, c_H_BP);
    localparam int c_V_TOTAL      = line_total(c_V_ACTIVE, c_V_FP, c_V_SYNC, c_V_BP);
    localparam int c_H_SYNC_START = c_H_ACTIVE + c_H_FP;
    localparam int c_H_SYNC_END   = c_H_SYNC_START + c_H_SYNC;
    localparam int c_V_SYNC_START = c_V_ACTIVE + c_V_FP;
    localparam int c_V_SYNC_END   = c_V_SYNC_START + c_V_SYNC;

    typedef logic [c_CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_if
// Description : VGA output bundle: syncs, colour and raster position.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    import vga_pkg::*;

    logic       h_sync;
    logic       v_sync;
    logic [2:0] vga_R;
    logic [2:0] vga_G;
    logic [1:0] vga_B;
    cnt_t       x_cnt;
    cnt_t       y_cnt;

    modport master (output h_sync, v_sync, vga_R, vga_G, vga_B, x_cnt, y_cnt);
    modport slave  (input  h_sync, v_sync, vga_R, vga_G, vga_B, x_cnt, y_cnt);
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Pixel enable, raster counters, sync and active-video decode.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP
) (
    input  wire  clk,
    input  wire  rst,
    output cnt_t o_x_cnt,
    output cnt_t o_y_cnt,
    output logic o_h_sync,
    output logic o_v_sync,
    output logic o_active
);

    localparam cnt_t c_H_LAST  = cnt_t'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam cnt_t c_V_LAST  = cnt_t'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam cnt_t c_H_ACT   = cnt_t'(H_ACTIVE);
    localparam cnt_t c_V_ACT   = cnt_t'(V_ACTIVE);
    localparam cnt_t c_HS_BEG  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t c_HS_END  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t c_VS_BEG  = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t c_VS_END  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    logic r_pix_en;
    cnt_t r_x_cnt;
    cnt_t r_y_cnt;

    // Pixel rate is half the system clock; the counters move on pix_en cycles only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_en <= 1'b0;
            r_x_cnt  <= '0;
            r_y_cnt  <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_x_cnt == c_H_LAST) begin
                    r_x_cnt <= '0;
                    if (r_y_cnt == c_V_LAST) begin
                        r_y_cnt <= '0;
                    end else begin
                        r_y_cnt <= r_y_cnt + 10'd1;
                    end
                end else begin
                    r_x_cnt <= r_x_cnt + 10'd1;
                end
            end
        end
    end

    assign o_x_cnt  = r_x_cnt;
    assign o_y_cnt  = r_y_cnt;
    assign o_h_sync = ~((r_x_cnt >= c_HS_BEG) && (r_x_cnt < c_HS_END));
    assign o_v_sync = ~((r_y_cnt >= c_VS_BEG) && (r_y_cnt < c_VS_END));
    assign o_active = (r_x_cnt < c_H_ACT) && (r_y_cnt < c_V_ACT);

endmodule
`default_nettype wire

// File: rtl/vga_core.sv
`default_nettype none
// ============================================================================
// Module      : vga_core
// Description : VGA timing generator with an eight-bar colour test pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP
) (
    input  wire   clk,
    input  wire   rst,
    vga_if.master vga
);

    localparam cnt_t c_BAR_W = cnt_t'(H_ACTIVE / 8);

    cnt_t       w_x_cnt;
    cnt_t       w_y_cnt;
    logic       w_h_sync;
    logic       w_v_sync;
    logic       w_active;
    logic [2:0] w_bar;
    rgb_t       w_rgb;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .o_x_cnt  (w_x_cnt),
        .o_y_cnt  (w_y_cnt),
        .o_h_sync (w_h_sync),
        .o_v_sync (w_v_sync),
        .o_active (w_active)
    );

    // Bar index bits map straight onto the colour channels: bit2 red, bit1 green, bit0 blue.
    assign w_bar = 3'(w_x_cnt / c_BAR_W);

    always_comb begin
        w_rgb = '0;
        if (w_active) begin
            w_rgb.r = {3{w_bar[2]}};
            w_rgb.g = {3{w_bar[1]}};
            w_rgb.b = {2{w_bar[0]}};
        end
    end

    assign vga.h_sync = w_h_sync;
    assign vga.v_sync = w_v_sync;
    assign vga.vga_R  = w_rgb.r;
    assign vga.vga_G  = w_rgb.g;
    assign vga.vga_B  = w_rgb.b;
    assign vga.x_cnt  = w_x_cnt;
    assign vga.y_cnt  = w_y_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_core
// Description : Directed bench for vga_core; short vertical timing (9 lines).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    vga_if vif();

    // Horizontal timing is the real 800-pixel line; vertical is 4+1+2+2 = 9 lines.
    vga_core #(
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    always #10 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_total++; if (vif.x_cnt !== 10'd0) $display("FAIL rst_x got %0d want 0", vif.x_cnt); else n_pass++;
        n_total++; if (vif.y_cnt !== 10'd0) $display("FAIL rst_y got %0d want 0", vif.y_cnt); else n_pass++;
        n_total++; if (vif.h_sync !== 1'b1) $display("FAIL rst_hs got %b want 1", vif.h_sync); else n_pass++;
        n_total++; if (vif.v_sync !== 1'b1) $display("FAIL rst_vs got %b want 1", vif.v_sync); else n_pass++;
        n_total++; if ({vif.vga_R, vif.vga_G, vif.vga_B} !== 8'h00)
            $display("FAIL rst_rgb got %h want 00", {vif.vga_R, vif.vga_G, vif.vga_B}); else n_pass++;
        rst = 1'b0;
        step(1);
        n_total++; if (vif.x_cnt !== 10'd0) $display("FAIL rel_edge1_x got %0d want 0", vif.x_cnt); else n_pass++;
        step(1);
        n_total++; if (vif.x_cnt !== 10'd1) $display("FAIL rel_edge2_x got %0d want 1", vif.x_cnt); else n_pass++;
    endtask

    task automatic test_hsync();
        int   t_fall0 = -1, t_rise = -1, t_fall1 = -1;
        int   x_fall = -1, x_rise = -1;
        logic prev;
        do_reset();
        prev = vif.h_sync;
        for (int n = 1; n <= 4000 && t_fall1 < 0; n++) begin
            step(1);
            if (prev && !vif.h_sync) begin
                if (t_fall0 < 0) begin t_fall0 = n; x_fall = int'(vif.x_cnt); end
                else t_fall1 = n;
            end
            if (!prev && vif.h_sync && t_rise < 0) begin t_rise = n; x_rise = int'(vif.x_cnt); end
            prev = vif.h_sync;
        end
        n_total++;
        if (t_fall1 < 0 || t_rise < 0) $display("FAIL hs_timeout fall0=%0d rise=%0d fall1=%0d", t_fall0, t_rise, t_fall1);
        else n_pass++;
        n_total++; if (x_fall !== 656) $display("FAIL hs_fall_x got %0d want 656", x_fall); else n_pass++;
        n_total++; if (x_rise !== 752) $display("FAIL hs_rise_x got %0d want 752", x_rise); else n_pass++;
        n_total++; if (t_fall0 !== 1312) $display("FAIL hs_fall_clk got %0d want 1312", t_fall0); else n_pass++;
        n_total++; if (t_rise - t_fall0 !== 192) $display("FAIL hs_width got %0d want 192", t_rise - t_fall0); else n_pass++;
        n_total++; if (t_fall1 - t_fall0 !== 1600) $display("FAIL hs_period got %0d want 1600", t_fall1 - t_fall0); else n_pass++;
    endtask

    task automatic test_vsync_frame();
        int   t_fall0 = -1, t_rise = -1, t_fall1 = -1;
        int   y_fall = -1, x_fall = -1, y_rise = -1;
        logic prev;
        do_reset();
        prev = vif.v_sync;
        for (int n = 1; n <= 30000 && t_fall1 < 0; n++) begin
            step(1);
            if (prev && !vif.v_sync) begin
                if (t_fall0 < 0) begin t_fall0 = n; y_fall = int'(vif.y_cnt); x_fall = int'(vif.x_cnt); end
                else t_fall1 = n;
            end
            if (!prev && vif.v_sync && t_rise < 0) begin t_rise = n; y_rise = int'(vif.y_cnt); end
            prev = vif.v_sync;
        end
        n_total++;
        if (t_fall1 < 0 || t_rise < 0) $display("FAIL vs_timeout fall0=%0d rise=%0d fall1=%0d", t_fall0, t_rise, t_fall1);
        else n_pass++;
        n_total++; if (y_fall !== 5) $display("FAIL vs_fall_y got %0d want 5", y_fall); else n_pass++;
        n_total++; if (x_fall !== 0) $display("FAIL vs_fall_x got %0d want 0", x_fall); else n_pass++;
        n_total++; if (y_rise !== 7) $display("FAIL vs_rise_y got %0d want 7", y_rise); else n_pass++;
        n_total++; if (t_fall0 !== 8000) $display("FAIL vs_fall_clk got %0d want 8000", t_fall0); else n_pass++;
        n_total++; if (t_rise - t_fall0 !== 3200) $display("FAIL vs_width got %0d want 3200", t_rise - t_fall0); else n_pass++;
        n_total++; if (t_fall1 - t_fall0 !== 14400) $display("FAIL vs_period got %0d want 14400", t_fall1 - t_fall0); else n_pass++;
    endtask

    task automatic test_colour_bars();
        do_reset();
        n_total++; if ({vif.vga_R, vif.vga_G, vif.vga_B} !== 8'h00)
            $display("FAIL bar_x0 got %h want 00", {vif.vga_R, vif.vga_G, vif.vga_B}); else n_pass++;
        step(158);
        n_total++; if ({vif.x_cnt, vif.vga_R, vif.vga_G, vif.vga_B} !== {10'd79, 8'h00})
            $display("FAIL bar_x79 got x=%0d rgb=%h want x=79 rgb=00", vif.x_cnt, {vif.vga_R, vif.vga_G, vif.vga_B}); else n_pass++;
        step(2);
        n_total++; if ({vif.x_cnt, vif.vga_R, vif.vga_G, vif.vga_B} !== {10'd80, 8'h03})
            $display("FAIL bar_x80 got x=%0d rgb=%h want x=80 rgb=03", vif.x_cnt, {vif.vga_R, vif.vga_G, vif.vga_B}); else n_pass++;
        step(318);
        n_total++; if ({vif.vga_R, vif.vga_G, vif.vga_B} !== 8'h1C)
            $display("FAIL bar_x239 got %h want 1c", {vif.vga_R, vif.vga_G, vif.vga_B}); else n_pass++;
        step(642);
        n_total++; if ({vif.x_cnt, vif.vga_R, vif.vga_G, vif.vga_B} !== {10'd560, 8'hFF})
            $display("FAIL bar_x560 got x=%0d rgb=%h want x=560 rgb=ff", vif.x_cnt, {vif.vga_R, vif.vga_G, vif.vga_B}); else n_pass++;
        step(160);
        n_total++; if ({vif.x_cnt, vif.vga_R, vif.vga_G, vif.vga_B} !== {10'd640, 8'h00})
            $display("FAIL bar_x640 got x=%0d rgb=%h want x=640 rgb=00", vif.x_cnt, {vif.vga_R, vif.vga_G, vif.vga_B}); else n_pass++;
        step(5280);
        n_total++; if ({vif.y_cnt, vif.x_cnt, vif.vga_R, vif.vga_G, vif.vga_B} !== {10'd4, 10'd80, 8'h00})
            $display("FAIL bar_vblank got y=%0d x=%0d rgb=%h want y=4 x=80 rgb=00",
                     vif.y_cnt, vif.x_cnt, {vif.vga_R, vif.vga_G, vif.vga_B}); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        step(1599);
        n_total++; if ({vif.x_cnt, vif.y_cnt} !== {10'd799, 10'd0})
            $display("FAIL line_end got x=%0d y=%0d want 799 0", vif.x_cnt, vif.y_cnt); else n_pass++;
        step(1);
        n_total++; if ({vif.x_cnt, vif.y_cnt} !== {10'd0, 10'd1})
            $display("FAIL line_wrap got x=%0d y=%0d want 0 1", vif.x_cnt, vif.y_cnt); else n_pass++;
        step(12799);
        n_total++; if ({vif.x_cnt, vif.y_cnt} !== {10'd799, 10'd8})
            $display("FAIL frame_end got x=%0d y=%0d want 799 8", vif.x_cnt, vif.y_cnt); else n_pass++;
        step(1);
        n_total++; if ({vif.x_cnt, vif.y_cnt} !== {10'd0, 10'd0})
            $display("FAIL frame_wrap got x=%0d y=%0d want 0 0", vif.x_cnt, vif.y_cnt); else n_pass++;
    endtask

    task automatic test_mid_frame_reset();
        do_reset();
        step(5000);
        n_total++; if ({vif.x_cnt, vif.y_cnt} !== {10'd100, 10'd3})
            $display("FAIL pre_rst_pos got x=%0d y=%0d want 100 3", vif.x_cnt, vif.y_cnt); else n_pass++;
        rst = 1'b1;
        step(1);
        n_total++; if ({vif.x_cnt, vif.y_cnt, vif.h_sync, vif.v_sync} !== {10'd0, 10'd0, 2'b11})
            $display("FAIL mid_rst got x=%0d y=%0d hs=%b vs=%b want 0 0 1 1",
                     vif.x_cnt, vif.y_cnt, vif.h_sync, vif.v_sync); else n_pass++;
        rst = 1'b0;
        step(2);
        n_total++; if (vif.x_cnt !== 10'd1) $display("FAIL restart_x1 got %0d want 1", vif.x_cnt); else n_pass++;
        step(1310);
        n_total++; if ({vif.x_cnt, vif.h_sync} !== {10'd656, 1'b0})
            $display("FAIL restart_hs got x=%0d hs=%b want 656 0", vif.x_cnt, vif.h_sync); else n_pass++;
        step(288);
        n_total++; if ({vif.x_cnt, vif.y_cnt} !== {10'd0, 10'd1})
            $display("FAIL restart_wrap got x=%0d y=%0d want 0 1", vif.x_cnt, vif.y_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_vsync_frame();
        test_colour_bars();
        test_wrap();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
